// File: rtl/mac_array_pkg.sv
// Shared types and sizing for the MAC array.
// Field widths here define the coefficient ROM address layout.
package mac_array_pkg;
    localparam int K_LEN  = 8;
    localparam int N_COL  = 4;
    localparam int ACC_W  = 19;
    localparam int X_W    = 8;
    localparam int K_W    = 3;
    localparam int COL_W  = 2;
    localparam int ADDR_W = COL_W + K_W;
    localparam int N_LANE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/mac_array_if.sv
// Bus between the MAC array, its X buffer / coefficient ROM and the consumer.
// The master side drives operands, the slave side is the array.
interface mac_array_if #(
    parameter int ACC_W = mac_array_pkg::ACC_W
);
    import mac_array_pkg::*;

    logic                start;
    logic [X_W-1:0]      x_reg1;
    logic [X_W-1:0]      x_reg2;
    logic [X_W-1:0]      x_reg3;
    logic [X_W-1:0]      x_reg4;
    logic [X_W-1:0]      coef;
    logic [ADDR_W-1:0]   coef_addr;
    logic                x_shift;
    logic [ACC_W-1:0]    result1;
    logic [ACC_W-1:0]    result2;
    logic [ACC_W-1:0]    result3;
    logic [ACC_W-1:0]    result4;
    logic                result_valid;
    logic [COL_W-1:0]    col_idx;
    logic                busy;
    logic                done;

    modport master (
        output start, x_reg1, x_reg2, x_reg3, x_reg4, coef,
        input  coef_addr, x_shift, result1, result2, result3, result4,
        input  result_valid, col_idx, busy, done
    );

    modport slave (
        input  start, x_reg1, x_reg2, x_reg3, x_reg4, coef,
        output coef_addr, x_shift, result1, result2, result3, result4,
        output result_valid, col_idx, busy, done
    );
endinterface

// File: rtl/mac_array_lane.sv
// One multiply-accumulate lane: 8x8 unsigned product into an ACC_W accumulator.
// clr has priority over en.
module mac_lane #(
    parameter int ACC_W = mac_array_pkg::ACC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic [mac_array_pkg::X_W-1:0] x,
    input  logic [mac_array_pkg::X_W-1:0] c,
    output logic [ACC_W-1:0]            acc
);
    import mac_array_pkg::*;

    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [2*X_W-1:0]   prod;

    always_comb begin
        prod  = {{X_W{1'b0}}, x} * {{X_W{1'b0}}, c};
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/mac_array.sv
// Four-row MAC array: K_LEN MAC cycles per column, one OUT cycle per column,
// N_COL columns per operation, then a one-cycle done pulse.
module mac_array #(
    parameter int K_LEN = mac_array_pkg::K_LEN,
    parameter int N_COL = mac_array_pkg::N_COL,
    parameter int ACC_W = mac_array_pkg::ACC_W
) (
    input  logic        clk,
    input  logic        rst,
    mac_array_if.slave  bus
);
    import mac_array_pkg::*;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(K_LEN - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);

    state_e             state_q;
    state_e             state_d;
    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     k_d;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   col_d;
    logic               lane_clr;
    logic               lane_en;
    logic [X_W-1:0]     x_lane [N_LANE];
    logic [ACC_W-1:0]   acc    [N_LANE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        col_d   = col_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_MAC;
                    k_d     = '0;
                    col_d   = '0;
                end
            end
            ST_MAC: begin
                if (k_q == K_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_OUT: begin
                k_d = '0;
                if (col_q == COL_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    col_d   = col_q + COL_W'(1);
                    state_d = ST_MAC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                k_d     = '0;
                col_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulators only run in MAC and are held at zero everywhere else.
    assign lane_en  = (state_q == ST_MAC);
    assign lane_clr = (state_q != ST_MAC);

    assign x_lane[0] = bus.x_reg1;
    assign x_lane[1] = bus.x_reg2;
    assign x_lane[2] = bus.x_reg3;
    assign x_lane[3] = bus.x_reg4;

    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        mac_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .en  (lane_en),
            .x   (x_lane[i]),
            .c   (bus.coef),
            .acc (acc[i])
        );
    end

    // Outputs are forced low while rst is high, even before the state clears.
    always_comb begin
        bus.coef_addr    = '0;
        bus.x_shift      = 1'b0;
        bus.result_valid = 1'b0;
        bus.col_idx      = '0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.result1      = '0;
        bus.result2      = '0;
        bus.result3      = '0;
        bus.result4      = '0;
        if (!rst) begin
            bus.busy = (state_q != ST_IDLE);
            unique case (state_q)
                ST_MAC: begin
                    bus.x_shift   = 1'b1;
                    bus.coef_addr = {col_q, k_q};
                end
                ST_OUT: begin
                    bus.result_valid = 1'b1;
                    bus.col_idx      = col_q;
                    bus.result1      = acc[0];
                    bus.result2      = acc[1];
                    bus.result3      = acc[2];
                    bus.result4      = acc[3];
                end
                ST_DONE: bus.done = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: X-buffer and ROM models, table vectors,
// random operands against a dot-product model, and reset/restart sequences.
module tb_mac_array;
    import mac_array_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_array_if bus ();

    mac_array dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] xbuf [4][8];
    logic [7:0] rom  [32];
    logic [2:0] ptr;

    // X buffer rotates one byte per shift; ROM is combinational.
    assign bus.x_reg1 = xbuf[0][ptr];
    assign bus.x_reg2 = xbuf[1][ptr];
    assign bus.x_reg3 = xbuf[2][ptr];
    assign bus.x_reg4 = xbuf[3][ptr];
    assign bus.coef   = rom[bus.coef_addr];

    always @(posedge clk) begin
        if (rst) ptr <= 3'd0;
        else if (bus.x_shift) ptr <= ptr + 3'd1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int exp_res [4][4];

    int shifts;
    int valids;
    int busy_low;
    int zero_bad;
    int dones [$];

    typedef struct {
        logic [7:0] xv;
        logic [7:0] cv;
        int         expv;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                int s;
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += int'(xbuf[i][k]) * int'(rom[c*8+k]);
                exp_res[c][i] = s;
            end
        end
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++)
                xbuf[i][k] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 32; a++)
            rom[a] = 8'($urandom_range(0, 255));
    endtask

    task automatic kick(input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = hold;
    endtask

    // Cycle 1 is the first cycle after the edge that sampled start.
    task automatic observe(input int ncyc, input bit poke);
        int base;
        shifts   = 0;
        valids   = 0;
        busy_low = 0;
        zero_bad = 0;
        dones.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (poke) bus.start = (c == 20);
            if (bus.x_shift === 1'b1) shifts++;
            if (bus.done === 1'b1) dones.push_back(c);
            if (bus.busy !== 1'b1) busy_low++;
            if (bus.result_valid === 1'b1) begin
                base = (c > 38) ? 38 : 0;
                chk("col_order", 32'(bus.col_idx), 32'(valids % 4));
                chk("valid_cycle", 32'(c - base),
                    32'(9 * int'(bus.col_idx) + 9));
                chk("result1", 32'(bus.result1), exp_res[bus.col_idx][0]);
                chk("result2", 32'(bus.result2), exp_res[bus.col_idx][1]);
                chk("result3", 32'(bus.result3), exp_res[bus.col_idx][2]);
                chk("result4", 32'(bus.result4), exp_res[bus.col_idx][3]);
                valids++;
            end else if (bus.result1 !== '0 || bus.result2 !== '0 ||
                         bus.result3 !== '0 || bus.result4 !== '0 ||
                         bus.col_idx !== '0) begin
                zero_bad++;
            end
        end
    endtask

    task automatic check_op(input string tag, input int e_valids,
                            input int e_shifts, input int e_low,
                            input int d0, input int d1);
        chk({tag, "_valids"}, valids, e_valids);
        chk({tag, "_shifts"}, shifts, e_shifts);
        chk({tag, "_idle_cycles"}, busy_low, e_low);
        chk({tag, "_zero_outside_out"}, zero_bad, 0);
        chk({tag, "_done_count"}, dones.size(), (d1 < 0) ? 1 : 2);
        chk({tag, "_done_cycle"}, (dones.size() > 0) ? dones[0] : -1, d0);
        if (d1 >= 0)
            chk({tag, "_done2_cycle"},
                (dones.size() > 1) ? dones[1] : -1, d1);
    endtask

    initial begin
        int found;
        int bad;

        tbl[0] = '{8'd1,   8'd1,   8};
        tbl[1] = '{8'd255, 8'd255, 520200};
        tbl[2] = '{8'd2,   8'd3,   48};
        tbl[3] = '{8'd0,   8'd200, 0};
        tbl[4] = '{8'd255, 8'd1,   2040};

        bus.start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) xbuf[i][k] = 8'd0;
        for (int a = 0; a < 32; a++) rom[a] = 8'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_x_shift", 32'(bus.x_shift), 0);
        chk("rst_coef_addr", 32'(bus.coef_addr), 0);
        chk("rst_result_valid", 32'(bus.result_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 8; k++) xbuf[i][k] = tbl[v].xv;
            for (int a = 0; a < 32; a++) rom[a] = tbl[v].cv;
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) exp_res[c][i] = tbl[v].expv;
            kick(1'b0);
            observe(39, 1'b0);
            check_op("tbl", 4, 32, 2, 37, -1);
        end

        // Diagonal coefficients pick out one X byte per column.
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) xbuf[i][k] = 8'((k + 1) * (i + 1));
        for (int a = 0; a < 32; a++) rom[a] = ((a / 8) == (a % 8)) ? 8'd1 : 8'd0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) exp_res[c][i] = (c + 1) * (i + 1);
        kick(1'b0);
        observe(39, 1'b0);
        check_op("diag", 4, 32, 2, 37, -1);

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            model();
            kick(1'b0);
            observe(39, 1'b0);
            check_op("rand", 4, 32, 2, 37, -1);
        end

        fill_rand();
        model();
        kick(1'b0);
        observe(39, 1'b1);
        check_op("start_busy", 4, 32, 2, 37, -1);

        fill_rand();
        model();
        kick(1'b0);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.coef_addr === 5'd4) found = 1;
        end
        chk("reach_k4", found, 1);
        rst = 1'b1;
        #1;
        chk("inrst_busy", 32'(bus.busy), 0);
        chk("inrst_x_shift", 32'(bus.x_shift), 0);
        chk("inrst_coef_addr", 32'(bus.coef_addr), 0);
        chk("inrst_valid", 32'(bus.result_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_x_shift", 32'(bus.x_shift), 0);
        chk("post_rst_coef_addr", 32'(bus.coef_addr), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad++;
        end
        chk("post_rst_stays_idle", bad, 0);
        kick(1'b0);
        observe(39, 1'b0);
        check_op("post_rst", 4, 32, 2, 37, -1);

        fill_rand();
        model();
        kick(1'b1);
        observe(76, 1'b0);
        bus.start = 1'b0;
        check_op("b2b", 8, 64, 2, 37, 75);
        repeat (3) @(negedge clk);
        chk("b2b_final_idle", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 SHALL have parameter K_LEN, default 8, meaning MAC cycles per output column.
REQ-002 SHALL have parameter N_COL, default 4, meaning columns per operation.
REQ-003 SHALL have parameter ACC_W, default 19, meaning accumulator/result width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  meaning begin operation; sampled only in IDLE, tied to X buffer load-done.
REQ-007 SHALL have ports x_reg1..x_reg4  input  8 each  meaning unsigned X row-head bytes from the X buffer.
REQ-008 SHALL have port coef  input  8  meaning unsigned coefficient; asynchronous ROM data, valid in the same cycle as coef_addr.
REQ-009 SHALL have port coef_addr  output  5  meaning coefficient ROM address {col[1:0], k[2:0]}.
REQ-010 SHALL have port x_shift  output  1  meaning rotate request to the X buffer.
REQ-011 SHALL have ports result1..result4  output  ACC_W each  meaning row dot products for the current column.
REQ-012 SHALL have port result_valid  output  1  meaning result1..4 valid this cycle.
REQ-013 SHALL have port col_idx  output  2  meaning column index of the current results.
REQ-014 SHALL have ports busy and done  output  1 each  meaning operation in progress / one-cycle completion pulse.

Function
REQ-015 FSM SHALL have states IDLE, MAC, OUT, DONE; binary encoded.
REQ-016 In IDLE with start=1, SHALL go to MAC with k=0, col=0, accumulators 0; otherwise stay in IDLE.
REQ-017 In MAC, each cycle SHALL do acc_i <= acc_i + x_reg_i*coef (8x8 unsigned product, zero-extended to ACC_W), drive x_shift=1, and drive coef_addr={col,k}.
REQ-018 In MAC with k=K_LEN-1, SHALL go to OUT; otherwise increment k.
REQ-019 In OUT, SHALL drive result_valid=1 with result_i=acc_i and col_idx=col; x_shift=0.
REQ-020 Leaving OUT, SHALL clear accumulators and set k=0; if col=N_COL-1 go to DONE, else increment col and go to MAC.
REQ-021 In DONE, SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-022 busy SHALL be 1 in MAC, OUT and DONE.
REQ-023 x_shift SHALL be 1 only in MAC, giving exactly K_LEN shifts per column so the X rows realign before the next column.
REQ-024 start SHALL be ignored outside IDLE; start held high SHALL restart from IDLE the cycle after DONE.
REQ-025 Accumulators SHALL not overflow: 8*255*255=520200 < 2^19.
REQ-026 Outside OUT, result_i, result_valid and col_idx SHALL be 0.
REQ-027 Latency: start at cycle 0 -> column j result_valid at cycle 9j+9 -> done at cycle 37.

Reset
REQ-028 rst=1 SHALL, at the next clock edge, force IDLE with k, col and accumulators at 0, overriding any state including mid-MAC.
REQ-029 During reset all outputs SHALL be 0, including coef_addr, x_shift, busy and done.

Structure
REQ-030 A shared package SHALL hold the state enum, K_LEN, N_COL, ACC_W and the coef_addr field widths.
REQ-031 Sub-module mac_lane SHALL implement one multiply-accumulate lane with clear and enable, instantiated four times.

Verification
REQ-032 Bench SHALL drive all X=1 and all coef=1 -> four result_valid pulses, each with all results=8 and col_idx 0..3, and done at cycle 37.
REQ-033 Bench SHALL drive all X=255 and coef=255 -> every result=520200 with no wrap.
REQ-034 Bench SHALL use a rotating X model with row i = bytes 1..8 scaled by i, and coef(col,k)=1 when k==col else 0 -> result_i = X[i][col] for each column.
REQ-035 Bench SHALL pulse start while busy -> no restart and an unchanged result sequence; assert rst in MAC at k=4 -> IDLE next cycle, all outputs 0, and a later start runs clean.
REQ-036 Bench SHALL hold start high -> back-to-back operations with one IDLE cycle between done and the next MAC, and x_shift count = 32 per operation.
